// File: rtl/att_ram_arbiter.sv
// Port-A arbiter for the 1024x8 character-attribute RAM: round-robin between two
// requesters plus a constant-fill engine. Define ATT_ARB_OREG_EN for an output-registered RAM.
module att_ram_arbiter #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ack,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ack,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  input  logic          fill_start,
  input  logic [AW-1:0] fill_base,
  input  logic [AW:0]   fill_len,
  input  logic [DW-1:0] fill_value,
  output logic          fill_busy,
  output logic          fill_done,
  output logic          ram_cea,
  output logic          ram_wrea,
  output logic [AW-1:0] ram_ada,
  output logic [DW-1:0] ram_dina,
  input  logic [DW-1:0] ram_douta,
  output logic          ram_ocea,
  output logic          dbg_state_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

`ifdef ATT_ARB_OREG_EN
  localparam int RD_STAGES = 2;
`else
  localparam int RD_STAGES = 1;
`endif

  logic [0:0]           state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [AW-1:0]        fill_addr_q, fill_addr_d;
  logic [AW:0]          fill_cnt_q, fill_cnt_d;
  logic [DW-1:0]        fill_value_q, fill_value_d;
  logic                 fill_done_q, fill_done_d;
  logic [RD_STAGES-1:0] rd_v_q, rd_v_d;
  logic [RD_STAGES-1:0] rd_tag_q, rd_tag_d;
  logic                 grant0, grant1;
  logic                 issue_rd, issue_tag;

  // last_grant_q == 1 means requester 1 was served last, so requester 0 wins a tie.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    fill_addr_d  = fill_addr_q;
    fill_cnt_d   = fill_cnt_q;
    fill_value_d = fill_value_q;
    fill_done_d  = 1'b0;
    grant0       = 1'b0;
    grant1       = 1'b0;
    issue_rd     = 1'b0;
    issue_tag    = 1'b0;
    ram_cea      = 1'b0;
    ram_wrea     = 1'b0;
    ram_ada      = '0;
    ram_dina     = '0;
    if (!reset) begin
      if (state_q == ST_IDLE) begin
        grant0 = r0_req && (!r1_req || last_grant_q);
        grant1 = r1_req && (!r0_req || !last_grant_q);
        if (grant0) begin
          ram_cea      = 1'b1;
          ram_wrea     = r0_we;
          ram_ada      = r0_addr;
          ram_dina     = r0_wdata;
          issue_rd     = !r0_we;
          last_grant_d = 1'b0;
        end else if (grant1) begin
          ram_cea      = 1'b1;
          ram_wrea     = r1_we;
          ram_ada      = r1_addr;
          ram_dina     = r1_wdata;
          issue_rd     = !r1_we;
          issue_tag    = 1'b1;
          last_grant_d = 1'b1;
        end
        if (fill_start) begin
          state_d      = ST_FILL;
          fill_addr_d  = fill_base;
          fill_cnt_d   = fill_len;
          fill_value_d = fill_value;
        end
      end else begin
        // A zero-length fill still spends one cycle here, just without a write.
        if (fill_cnt_q != '0) begin
          ram_cea     = 1'b1;
          ram_wrea    = 1'b1;
          ram_ada     = fill_addr_q;
          ram_dina    = fill_value_q;
          fill_addr_d = fill_addr_q + 1'b1;
          fill_cnt_d  = fill_cnt_q - 1'b1;
        end
        if (fill_cnt_q <= CNT_ONE) begin
          state_d     = ST_IDLE;
          fill_done_d = 1'b1;
        end
      end
    end
  end

`ifdef ATT_ARB_OREG_EN
  always_comb begin
    rd_v_d   = {rd_v_q[0], issue_rd};
    rd_tag_d = {rd_tag_q[0], issue_tag};
  end
  assign ram_ocea = 1'b1;
`else
  always_comb begin
    rd_v_d   = issue_rd;
    rd_tag_d = issue_tag;
  end
  assign ram_ocea = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      fill_addr_q  <= '0;
      fill_cnt_q   <= '0;
      fill_value_q <= '0;
      fill_done_q  <= 1'b0;
      rd_v_q       <= '0;
      rd_tag_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      fill_addr_q  <= fill_addr_d;
      fill_cnt_q   <= fill_cnt_d;
      fill_value_q <= fill_value_d;
      fill_done_q  <= fill_done_d;
      rd_v_q       <= rd_v_d;
      rd_tag_q     <= rd_tag_d;
    end
  end

  assign r0_ack      = grant0;
  assign r1_ack      = grant1;
  assign r0_rvalid   = rd_v_q[RD_STAGES-1] && !rd_tag_q[RD_STAGES-1];
  assign r1_rvalid   = rd_v_q[RD_STAGES-1] && rd_tag_q[RD_STAGES-1];
  assign r0_rdata    = r0_rvalid ? ram_douta : '0;
  assign r1_rdata    = r1_rvalid ? ram_douta : '0;
  assign fill_busy   = (state_q == ST_FILL);
  assign fill_done   = fill_done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_att_ram_arbiter.sv
// Bench for att_ram_arbiter: vector table, hand-written fill/reset sequences and a
// randomized run checked against a timeline model of the arbiter and fill engine.
module tb_att_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        r0_req = 1'b0, r0_we = 1'b0;
  logic [9:0]  r0_addr = '0;
  logic [7:0]  r0_wdata = '0;
  logic        r1_req = 1'b0, r1_we = 1'b0;
  logic [9:0]  r1_addr = '0;
  logic [7:0]  r1_wdata = '0;
  logic        fill_start = 1'b0;
  logic [9:0]  fill_base = '0;
  logic [10:0] fill_len = '0;
  logic [7:0]  fill_value = '0;
  logic        r0_ack, r0_rvalid, r1_ack, r1_rvalid;
  logic [7:0]  r0_rdata, r1_rdata;
  logic        fill_busy, fill_done, ram_cea, ram_wrea, ram_ocea, dbg_state;
  logic [9:0]  ram_ada;
  logic [7:0]  ram_dina;
  logic [7:0]  ram_douta;

  always #5 clk = ~clk;

  att_ram_arbiter #(.AW(10), .DW(8)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
    .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done),
    .ram_cea(ram_cea), .ram_wrea(ram_wrea), .ram_ada(ram_ada), .ram_dina(ram_dina),
    .ram_douta(ram_douta), .ram_ocea(ram_ocea), .dbg_state_o(dbg_state)
  );

  // Port-A RAM in bypass read mode
  logic [7:0] tb_mem [0:1023];
  always @(posedge clk) begin
    if (ram_cea) begin
      if (ram_wrea) tb_mem[ram_ada] <= ram_dina;
      else          ram_douta <= tb_mem[ram_ada];
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  // {ack0,ack1,cea,wrea} {ada} {dina} {busy,done,rv0,rv1}
  function automatic logic [25:0] obs();
    return {r0_ack, r1_ack, ram_cea, ram_wrea, ram_ada, ram_dina,
            fill_busy, fill_done, r0_rvalid, r1_rvalid};
  endfunction

  function automatic logic [25:0] ex(input logic [3:0] hi, input logic [9:0] ad,
                                     input logic [7:0] d, input logic [3:0] lo);
    return {hi, ad, d, lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [25:0] e);
    @(negedge clk);
    check(nm, 32'(obs()), 32'(e));
  endtask

  task automatic idle_inputs();
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
    fill_start = 1'b0;
  endtask

  task automatic start_fill(input logic [9:0] b, input logic [10:0] l, input logic [7:0] v);
    fill_start = 1'b1; fill_base = b; fill_len = l; fill_value = v;
  endtask

  typedef struct {
    logic [1:0] r0_rw;
    logic [9:0] r0_a;
    logic [7:0] r0_d;
    logic [1:0] r1_rw;
    logic [9:0] r1_a;
    logic [7:0] r1_d;
    logic [25:0] e;
    logic [7:0] e_rdata;
  } vec_t;

  function automatic vec_t v(input logic [1:0] rw0, input logic [9:0] a0, input logic [7:0] d0,
                             input logic [1:0] rw1, input logic [9:0] a1, input logic [7:0] d1,
                             input logic [25:0] e, input logic [7:0] rd);
    vec_t t;
    t.r0_rw = rw0; t.r0_a = a0; t.r0_d = d0;
    t.r1_rw = rw1; t.r1_a = a1; t.r1_d = d1;
    t.e = e; t.e_rdata = rd;
    return t;
  endfunction

  vec_t tbl [15];
  logic [9:0] fa_addr [4];

  // timeline model state for the randomized run
  logic [7:0] shadow [0:1023];
  bit         f_act;
  int         f_t0, f_len, cyc, pend, span, k, g, fl;
  logic [9:0] f_base, fb, e_ada;
  logic [7:0] f_val, fv, pend_data, e_din;
  logic [3:0] e_hi, e_lo;
  bit         last_r1, busy, done, fs;
  bit         rq [2];
  bit         rwe [2];
  logic [9:0] raddr [2];
  logic [7:0] rwd [2];

  initial begin
    // rw = {req, we}
    tbl[0]  = v(2'b11, 10'h005, 8'h41, 2'b00, 10'h000, 8'h00, ex(4'b1011, 10'h005, 8'h41, 4'b0000), 8'h00);
    tbl[1]  = v(2'b10, 10'h005, 8'h00, 2'b00, 10'h000, 8'h00, ex(4'b1010, 10'h005, 8'h00, 4'b0000), 8'h00);
    tbl[2]  = v(2'b00, 10'h000, 8'h00, 2'b00, 10'h000, 8'h00, ex(4'b0000, 10'h000, 8'h00, 4'b0010), 8'h41);
    tbl[3]  = v(2'b00, 10'h000, 8'h00, 2'b11, 10'h010, 8'h77, ex(4'b0111, 10'h010, 8'h77, 4'b0000), 8'h00);
    tbl[4]  = v(2'b11, 10'h011, 8'h88, 2'b11, 10'h012, 8'h99, ex(4'b1011, 10'h011, 8'h88, 4'b0000), 8'h00);
    tbl[5]  = v(2'b10, 10'h005, 8'h5A, 2'b11, 10'h012, 8'h99, ex(4'b0111, 10'h012, 8'h99, 4'b0000), 8'h00);
    tbl[6]  = v(2'b10, 10'h005, 8'h5A, 2'b10, 10'h010, 8'h00, ex(4'b1010, 10'h005, 8'h5A, 4'b0000), 8'h00);
    tbl[7]  = v(2'b10, 10'h011, 8'h00, 2'b10, 10'h010, 8'h00, ex(4'b0110, 10'h010, 8'h00, 4'b0010), 8'h41);
    tbl[8]  = v(2'b10, 10'h011, 8'h00, 2'b10, 10'h012, 8'h00, ex(4'b1010, 10'h011, 8'h00, 4'b0001), 8'h77);
    tbl[9]  = v(2'b10, 10'h005, 8'h00, 2'b10, 10'h012, 8'h00, ex(4'b0110, 10'h012, 8'h00, 4'b0010), 8'h88);
    tbl[10] = v(2'b10, 10'h005, 8'h00, 2'b10, 10'h011, 8'h00, ex(4'b1010, 10'h005, 8'h00, 4'b0001), 8'h99);
    tbl[11] = v(2'b10, 10'h010, 8'h00, 2'b10, 10'h011, 8'h00, ex(4'b0110, 10'h011, 8'h00, 4'b0010), 8'h41);
    tbl[12] = v(2'b10, 10'h010, 8'h00, 2'b00, 10'h000, 8'h00, ex(4'b1010, 10'h010, 8'h00, 4'b0001), 8'h88);
    tbl[13] = v(2'b00, 10'h000, 8'h00, 2'b00, 10'h000, 8'h00, ex(4'b0000, 10'h000, 8'h00, 4'b0010), 8'h77);
    tbl[14] = v(2'b00, 10'h000, 8'h00, 2'b00, 10'h000, 8'h00, ex(4'b0000, 10'h000, 8'h00, 4'b0000), 8'h00);
    fa_addr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};

    // reset state, requests raised to show they are ignored under reset
    idle_inputs();
    r0_req = 1'b1; r1_req = 1'b1;
    tick(); tick();
    chk("reset_outputs", 26'h0);
    check("reset_rdata", {16'h0, r0_rdata, r1_rdata}, 32'h0);
    idle_inputs();
    reset = 1'b0;

    // arbitration / read-latency vectors
    for (int i = 0; i < 15; i++) begin
      {r0_req, r0_we} = tbl[i].r0_rw; r0_addr = tbl[i].r0_a; r0_wdata = tbl[i].r0_d;
      {r1_req, r1_we} = tbl[i].r1_rw; r1_addr = tbl[i].r1_a; r1_wdata = tbl[i].r1_d;
      chk($sformatf("vec%0d", i), tbl[i].e);
      if (tbl[i].e[1]) check($sformatf("vec%0d_r0_rdata", i), 32'(r0_rdata), 32'(tbl[i].e_rdata));
      if (tbl[i].e[0]) check($sformatf("vec%0d_r1_rdata", i), 32'(r1_rdata), 32'(tbl[i].e_rdata));
      tick();
    end
    idle_inputs();

    // wrapping fill of four bytes
    start_fill(10'h3FE, 11'd4, 8'h20);
    chk("fillA_start", 26'h0);
    tick(); fill_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fillA_w%0d", i), ex(4'b0011, fa_addr[i], 8'h20, 4'b1000));
      tick();
    end
    chk("fillA_done", ex(4'b0000, 10'h0, 8'h0, 4'b0100));
    tick();
    chk("fillA_after", 26'h0);
    tick();

    // requester held off by a fill; second fill_start ignored
    start_fill(10'h100, 11'd3, 8'h33);
    chk("fillB_start", 26'h0);
    tick(); fill_start = 1'b0; r1_req = 1'b1; r1_we = 1'b0; r1_addr = 10'h005;
    chk("fillB_w0", ex(4'b0011, 10'h100, 8'h33, 4'b1000));
    tick(); start_fill(10'h200, 11'd5, 8'hEE);
    chk("fillB_w1", ex(4'b0011, 10'h101, 8'h33, 4'b1000));
    tick(); fill_start = 1'b0;
    chk("fillB_w2", ex(4'b0011, 10'h102, 8'h33, 4'b1000));
    tick();
    chk("fillB_done_ack", ex(4'b0110, 10'h005, 8'h00, 4'b0100));
    tick(); r1_req = 1'b0;
    chk("fillB_rvalid", ex(4'b0000, 10'h0, 8'h0, 4'b0001));
    check("fillB_rdata", 32'(r1_rdata), 32'h41);
    tick();
    chk("fillB_no_refill0", 26'h0);
    tick();
    chk("fillB_no_refill1", 26'h0);
    tick();

    // zero-length fill
    start_fill(10'h050, 11'd0, 8'hAA);
    chk("fillC_start", 26'h0);
    tick(); fill_start = 1'b0;
    chk("fillC_busy", ex(4'b0000, 10'h0, 8'h0, 4'b1000));
    tick();
    chk("fillC_done", ex(4'b0000, 10'h0, 8'h0, 4'b0100));
    tick();
    chk("fillC_after", 26'h0);
    tick();

    // read acked alongside fill_start, then reset in the second write cycle
    start_fill(10'h080, 11'd10, 8'h11);
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 10'h005;
    chk("rst_start_ack", ex(4'b1010, 10'h005, 8'h00, 4'b0000));
    tick(); fill_start = 1'b0; r0_req = 1'b0;
    chk("rst_w0", ex(4'b0011, 10'h080, 8'h11, 4'b1010));
    check("rst_w0_rdata", 32'(r0_rdata), 32'h41);
    tick();
    r0_req = 1'b1; r0_addr = 10'h080; r1_req = 1'b1; r1_addr = 10'h080;
    #2 reset = 1'b1;
    chk("rst_abort", 26'h0);
    tick();
    chk("rst_hold", 26'h0);
    tick(); reset = 1'b0;
    chk("rst_r0_first", ex(4'b1010, 10'h080, 8'h00, 4'b0000));
    tick(); r0_req = 1'b0;
    chk("rst_r1_next", ex(4'b0110, 10'h080, 8'h00, 4'b0010));
    check("rst_r0_rdata", 32'(r0_rdata), 32'h11);
    tick(); r1_req = 1'b0;
    chk("rst_r1_rvalid", ex(4'b0000, 10'h0, 8'h0, 4'b0001));
    check("rst_r1_rdata", 32'(r1_rdata), 32'h11);
    tick();
    chk("rst_quiet", 26'h0);

    // randomized run: starts with a full-RAM fill through address 0
    idle_inputs();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    f_act = 1'b0; f_t0 = 0; f_len = 0; f_base = '0; f_val = '0;
    last_r1 = 1'b1; pend = -1; pend_data = '0; cyc = 0;
    for (int i = 0; i < 1024; i++) shadow[i] = 8'h00;
    for (int i = 0; i < 2; i++) begin rq[i] = 1'b0; rwe[i] = 1'b0; raddr[i] = '0; rwd[i] = '0; end
    for (int c = 0; c < 2600; c++) begin
      fs = 1'b0; fb = '0; fl = 0; fv = '0;
      if (c == 0) begin
        fs = 1'b1; fb = 10'h2A5; fl = 1024; fv = 8'hC3;
      end else begin
        for (int i = 0; i < 2; i++)
          if (!rq[i] && $urandom_range(0, 2) == 0) begin
            rq[i] = 1'b1; rwe[i] = 1'($urandom_range(0, 1));
            raddr[i] = 10'($urandom_range(0, 15)); rwd[i] = 8'($urandom);
          end
        if ($urandom_range(0, 29) == 0) begin
          fs = 1'b1; fb = 10'($urandom_range(0, 1023)); fl = $urandom_range(0, 6); fv = 8'($urandom);
        end
      end
      r0_req = rq[0]; r0_we = rwe[0]; r0_addr = raddr[0]; r0_wdata = rwd[0];
      r1_req = rq[1]; r1_we = rwe[1]; r1_addr = raddr[1]; r1_wdata = rwd[1];
      fill_start = fs; fill_base = fb; fill_len = 11'(fl); fill_value = fv;

      span = (f_len == 0) ? 1 : f_len;
      k = cyc - f_t0;
      busy = f_act && k >= 1 && k <= span;
      done = f_act && k == span + 1;
      e_hi = 4'b0000; e_ada = '0; e_din = '0; g = -1;
      if (busy) begin
        if (k - 1 < f_len) begin
          e_hi = 4'b0011; e_ada = 10'((int'(f_base) + k - 1) % 1024); e_din = f_val;
        end
      end else begin
        if (rq[0] && rq[1]) g = last_r1 ? 0 : 1;
        else if (rq[0]) g = 0;
        else if (rq[1]) g = 1;
        if (g >= 0) begin
          e_hi = {g == 0, g == 1, 1'b1, rwe[g]}; e_ada = raddr[g]; e_din = rwd[g];
        end
      end
      e_lo = {busy, done, pend == 0, pend == 1};
      chk($sformatf("rand_c%0d", c), ex(e_hi, e_ada, e_din, e_lo));
      if (pend == 0) check($sformatf("rand_c%0d_r0_rdata", c), 32'(r0_rdata), 32'(pend_data));
      if (pend == 1) check($sformatf("rand_c%0d_r1_rdata", c), 32'(r1_rdata), 32'(pend_data));

      if (busy && k - 1 < f_len) shadow[e_ada] = f_val;
      pend = -1;
      if (g >= 0) begin
        last_r1 = (g == 1);
        if (rwe[g]) shadow[raddr[g]] = rwd[g];
        else begin pend = g; pend_data = shadow[raddr[g]]; end
        rq[g] = 1'b0;
        if ($urandom_range(0, 1) == 1) begin
          rq[g] = 1'b1; rwe[g] = 1'($urandom_range(0, 1));
          raddr[g] = 10'($urandom_range(0, 15)); rwd[g] = 8'($urandom);
        end
      end
      if (f_act && k >= span + 1) f_act = 1'b0;
      if (fs && !busy) begin
        f_act = 1'b1; f_t0 = cyc; f_base = fb; f_len = fl; f_val = fv;
      end
      cyc++;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
